// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer: the op encoding from EX and the FSM state.
package muldiv_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL,
        OP_DIV,
        OP_MADD,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL_BUSY,
        MD_DIV_BUSY
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring unsigned divider, one quotient bit per clock. Outputs show the state after the
// step taken on the coming edge, so the final bit is visible in the last busy cycle.
module muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        // Top bit of diff is the borrow: restore when the trial subtract goes negative.
        if (!diff[WIDTH]) begin
            remainder = diff[WIDTH-1:0];
            quotient  = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            remainder = shifted[WIDTH-1:0];
            quotient  = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. Fixed-latency multiply through a
// product shift register; iterative divide with sign fix-up and special cases handled here.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_BITS   = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            op_valid,
    input  muldiv_op_t      op,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_BITS) ? MUL_CYCLES : DIV_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    muldiv_state_t state, next_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0]  hi, lo, hi_nxt, lo_nxt;
    logic [XLEN-1:0]  a_q, b_q;
    logic             sgn_q, madd_q;

    logic op_req, accept, div_start;
    logic [2*XLEN-1:0] ext_a, ext_b, product;
    logic [MUL_CYCLES-1:0][2*XLEN-1:0] mul_pipe;
    logic [2*XLEN-1:0] mul_res;

    logic [XLEN-1:0] mag_a, mag_b, div_q, div_r, q_fix, r_fix, div_lo, div_hi;

    assign op_req    = op_valid && (op != OP_NONE);
    assign stall     = op_req && (state != MD_IDLE) && !flush;
    assign accept    = op_req && !stall && !flush;
    assign div_start = accept && (op == OP_DIV);
    assign busy      = (state != MD_IDLE);
    assign hi_o      = hi;
    assign lo_o      = lo;

    // Product of the accept-cycle operands enters the shift chain and emerges MUL_CYCLES later.
    assign ext_a   = is_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    assign ext_b   = is_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    assign product = ext_a * ext_b;
    assign mul_res = mul_pipe[MUL_CYCLES-1];

    always_ff @(posedge clock) begin
        mul_pipe[0] <= product;
        for (int i = 1; i < MUL_CYCLES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    assign mag_a = (is_signed && a[XLEN-1]) ? -a : a;
    assign mag_b = (is_signed && b[XLEN-1]) ? -b : b;

    muldiv_div_iter #(.WIDTH(XLEN)) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Quotient negative when operand signs differ; remainder follows the dividend.
    assign q_fix = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_q : div_q;
    assign r_fix = (sgn_q && a_q[XLEN-1]) ? -div_r : div_r;

    always_comb begin
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else if (sgn_q && (a_q == 32'h8000_0000) && (b_q == '1)) begin
            div_lo = 32'h8000_0000;
            div_hi = '0;
        end else begin
            div_lo = q_fix;
            div_hi = r_fix;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = '0;
        hi_nxt     = hi;
        lo_nxt     = lo;
        result     = '0;
        case (state)
            MD_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MUL, OP_MADD: next_state = MD_MUL_BUSY;
                        OP_DIV:          next_state = MD_DIV_BUSY;
                        OP_MTHI:         hi_nxt = a;
                        OP_MTLO:         lo_nxt = a;
                        OP_MFHI:         result = hi;
                        OP_MFLO:         result = lo;
                        default: ;
                    endcase
                end
            end
            MD_MUL_BUSY: begin
                if (flush) begin
                    next_state = MD_IDLE;
                end else if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                    next_state = MD_IDLE;
                    {hi_nxt, lo_nxt} = madd_q ? ({hi, lo} + mul_res) : mul_res;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            MD_DIV_BUSY: begin
                if (flush) begin
                    next_state = MD_IDLE;
                end else if (cnt == CNT_W'(DIV_BITS - 1)) begin
                    next_state = MD_IDLE;
                    hi_nxt     = div_hi;
                    lo_nxt     = div_lo;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: next_state = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            madd_q <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                sgn_q  <= is_signed;
                madd_q <= (op == OP_MADD);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of arithmetic vectors plus hand-written
// sequences for stall latency, flush, reset and flush-vs-op_valid.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        op_valid;
    muldiv_op_t  op;
    logic        is_signed;
    logic [31:0] a, b;
    logic        flush;
    logic        stall, busy;
    logic [31:0] result, hi_o, lo_o;

    int total  = 0;
    int passed = 0;

    muldiv_ctrl #(.MUL_CYCLES(3), .DIV_BITS(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op        (op),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .result    (result),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        muldiv_op_t  op;
        logic        sgn;
        logic [31:0] a, b, ihi, ilo, ehi, elo;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one op from a negedge, wait out any stall, capture result in the accept cycle.
    task automatic issue(input muldiv_op_t o, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, output int nstall, output logic [31:0] res);
        nstall = 0;
        @(negedge clock);
        op_valid = 1'b1; op = o; is_signed = s; a = av; b = bv;
        #1;
        while (stall && nstall < 200) begin
            nstall++;
            @(negedge clock);
            #1;
        end
        if (stall) begin
            total++;
            $display("FAIL issue_timeout: stall still high after %0d cycles, op %0d", nstall, o);
        end
        res = result;
        @(posedge clock);
        #1;
        op_valid = 1'b0; op = OP_NONE;
    endtask

    initial begin
        int          ns;
        logic [31:0] r;

        reset_n = 1'b0; op_valid = 1'b0; op = OP_NONE; is_signed = 1'b0;
        a = '0; b = '0; flush = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_result", result, 32'h0);

        //           op       sgn  a             b             ihi           ilo           ehi           elo           lat
        vecs[0]  = '{OP_MUL,  1'b1, 32'd7,        32'hFFFF_FFFD, 32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 3};
        vecs[1]  = '{OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'hFFFF_FFFE, 32'h0000_0001, 3};
        vecs[2]  = '{OP_MUL,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'h0,         32'h1,         3};
        vecs[3]  = '{OP_DIV,  1'b0, 32'd100,      32'd7,         32'h0,        32'h0,        32'd2,         32'd14,        32};
        vecs[4]  = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,         32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 32};
        vecs[5]  = '{OP_DIV,  1'b0, 32'd5,        32'd0,         32'h0,        32'h0,        32'd5,         32'hFFFF_FFFF, 32};
        vecs[6]  = '{OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'h0,         32'h8000_0000, 32};
        vecs[7]  = '{OP_MADD, 1'b0, 32'd1,        32'd1,         32'h0,        32'hFFFF_FFFF, 32'h1,         32'h0,         3};
        vecs[8]  = '{OP_MADD, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,        32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};
        vecs[9]  = '{OP_DIV,  1'b1, 32'd7,        32'hFFFF_FFFE, 32'h0,        32'h0,        32'd1,         32'hFFFF_FFFD, 32};
        vecs[10] = '{OP_DIV,  1'b0, 32'hFFFF_FFFF, 32'd2,         32'h0,        32'h0,        32'd1,         32'h7FFF_FFFF, 32};
        vecs[11] = '{OP_DIV,  1'b1, 32'hFFFF_FFFB, 32'd0,         32'h0,        32'h0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 32};
        vecs[12] = '{OP_MADD, 1'b1, 32'd3,        32'hFFFF_FFFE, 32'h0,        32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};

        for (int i = 0; i < 13; i++) begin
            issue(OP_MTHI, 1'b0, vecs[i].ihi, 32'h0, ns, r);
            issue(OP_MTLO, 1'b0, vecs[i].ilo, 32'h0, ns, r);
            issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, ns, r);
            issue(OP_MFLO, 1'b0, 32'h0, 32'h0, ns, r);
            check($sformatf("vec%0d_mflo_stalls", i), 32'(ns), 32'(vecs[i].lat));
            check($sformatf("vec%0d_lo", i), r, vecs[i].elo);
            issue(OP_MFHI, 1'b0, 32'h0, 32'h0, ns, r);
            check($sformatf("vec%0d_mfhi_stalls", i), 32'(ns), 32'h0);
            check($sformatf("vec%0d_hi", i), r, vecs[i].ehi);
            check($sformatf("vec%0d_hi_o", i), hi_o, vecs[i].ehi);
        end

        // MTLO followed directly by MFLO sees the new value with no stall.
        issue(OP_MTLO, 1'b0, 32'h1234_5678, 32'h0, ns, r);
        issue(OP_MFLO, 1'b0, 32'h0, 32'h0, ns, r);
        check("mtlo_mflo_val", r, 32'h1234_5678);
        check("mtlo_mflo_stall", 32'(ns), 32'h0);

        // Busy stays high through the whole divide.
        issue(OP_DIV, 1'b0, 32'd100, 32'd7, ns, r);
        @(negedge clock);
        check("div_busy_start", {31'b0, busy}, 32'h1);
        repeat (30) @(negedge clock);
        check("div_busy_cycle31", {31'b0, busy}, 32'h1);
        @(negedge clock);
        check("div_busy_cycle32", {31'b0, busy}, 32'h1);
        @(negedge clock);
        check("div_busy_drop", {31'b0, busy}, 32'h0);
        check("div_lo_after", lo_o, 32'd14);

        // Flush mid-divide leaves HI/LO untouched; flush also beats a concurrent op.
        issue(OP_MTHI, 1'b0, 32'h55, 32'h0, ns, r);
        issue(OP_MTLO, 1'b0, 32'h55, 32'h0, ns, r);
        issue(OP_DIV, 1'b0, 32'd100, 32'd7, ns, r);
        repeat (9) @(negedge clock);
        flush = 1'b1; op_valid = 1'b1; op = OP_MFLO;
        #1;
        check("flush_busy_before", {31'b0, busy}, 32'h1);
        check("flush_stall", {31'b0, stall}, 32'h0);
        check("flush_result", result, 32'h0);
        @(posedge clock);
        #1 flush = 1'b0; op_valid = 1'b0; op = OP_NONE;
        check("flush_busy_after", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clock);
        check("flush_hi", hi_o, 32'h55);
        check("flush_lo", lo_o, 32'h55);

        // MFHI in IDLE returns HI combinationally in the accept cycle.
        @(negedge clock);
        op_valid = 1'b1; op = OP_MFHI;
        #1;
        check("mfhi_idle_stall", {31'b0, stall}, 32'h0);
        check("mfhi_idle_result", result, 32'h55);
        @(posedge clock);
        #1 op_valid = 1'b0; op = OP_NONE;

        // MUL presented with flush is never accepted.
        @(negedge clock);
        op_valid = 1'b1; op = OP_MUL; is_signed = 1'b0; a = 32'd2; b = 32'd3; flush = 1'b1;
        #1;
        check("mulflush_stall", {31'b0, stall}, 32'h0);
        @(posedge clock);
        #1 op_valid = 1'b0; op = OP_NONE; flush = 1'b0;
        check("mulflush_busy", {31'b0, busy}, 32'h0);
        repeat (5) @(negedge clock);
        check("mulflush_lo", lo_o, 32'h55);

        // Reset during a multiply discards it.
        issue(OP_MUL, 1'b0, 32'd3, 32'd4, ns, r);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_hi", hi_o, 32'h0);
        check("rst_mid_lo", lo_o, 32'h0);
        repeat (5) @(negedge clock);
        check("rst_mid_lo_later", lo_o, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
